// File: rtl/mesi_snoop_bus.sv
// mesi_snoop_bus
//   Shared snooping bus between per-core MESI state machines. A round-robin
//   arbiter picks one eligible core request, the bus broadcasts it to every
//   listener for one cycle, samples the listeners' line states, optionally
//   sequences a modified-line write-back to memory, and returns the resolved
//   transition code to the winning core.
//
// Ports
//   clock, reset                 single clock; synchronous active-low reset
//   req_valid/req_msg/req_addr   per-core bus requests (msg 11 = none)
//   req_ready                    one-cycle grant pulse to the winner
//   snoop_state/snoop_wb         per-core line state and write-back flag
//   bcast_*                      broadcast message, address, source index
//   listen_trans                 transition code for the listeners
//   mem_wb_valid/src/ack         write-back handshake towards memory
//   exec_valid/sel/trans         one-cycle result pulse to the winner
//   err                          sticky write-back timeout flag
module mesi_snoop_bus #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_W     = 8,
    parameter int WB_TIMEOUT = 15
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_valid,
    input  logic [2*NUM_CORES-1:0]      req_msg,
    input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [2*NUM_CORES-1:0]      snoop_state,
    input  logic [NUM_CORES-1:0]        snoop_wb,
    output logic                        bcast_valid,
    output logic [1:0]                  bcast_msg,
    output logic [ADDR_W-1:0]           bcast_addr,
    output logic [2:0]                  bcast_src,
    output logic [2:0]                  listen_trans,
    output logic                        mem_wb_valid,
    output logic [2:0]                  mem_wb_src,
    input  logic                        mem_wb_ack,
    output logic                        exec_valid,
    output logic [NUM_CORES-1:0]        exec_sel,
    output logic [2:0]                  exec_trans,
    output logic                        err
);

    typedef enum logic [1:0] {IDLE, SNOOP, WB_WAIT, RESP} state_t;

    state_t state, state_nx;

    // Per-transaction capture; bcast_src and bcast_addr double as the
    // captured winner index and address for the whole transaction.
    logic [1:0]           cap_msg, cap_msg_nx;
    logic                 hit_q, hit_nx;
    logic [2:0]           owner_q, owner_nx;

    logic [2:0]           rr_ptr, rr_ptr_nx;
    logic [3:0]           wb_cnt, wb_cnt_nx;
    logic                 wb_seen, wb_seen_nx;

    logic [NUM_CORES-1:0] req_ready_nx, exec_sel_nx;
    logic                 bcast_valid_nx, mem_wb_valid_nx, exec_valid_nx, err_nx;
    logic [1:0]           bcast_msg_nx;
    logic [ADDR_W-1:0]    bcast_addr_nx;
    logic [2:0]           bcast_src_nx, listen_trans_nx, mem_wb_src_nx, exec_trans_nx;

    // Arbitration / snoop evaluation
    logic [NUM_CORES-1:0] elig;
    logic                 win_found;
    logic [2:0]           win_c;
    logic [1:0]           win_msg;
    logic [ADDR_W-1:0]    win_addr;
    logic                 hit_c, own_found_c, own_wb;
    logic [2:0]           own_c;
    int                   idx;

    function automatic logic [2:0] resp_code(input logic [1:0] msg, input logic hit);
        logic [2:0] code;
        case (msg)
            2'b00:   code = hit ? 3'b000 : 3'b110;
            2'b01:   code = 3'b010;
            default: code = 3'b011;
        endcase
        return code;
    endfunction

    always_comb begin
        elig        = '0;
        win_found   = 1'b0;
        win_c       = 3'd0;
        win_msg     = 2'b11;
        win_addr    = '0;
        hit_c       = 1'b0;
        own_found_c = 1'b0;
        own_c       = 3'd0;
        own_wb      = 1'b0;
        idx         = 0;

        for (int i = 0; i < NUM_CORES; i++)
            elig[i] = req_valid[i] && (req_msg[2*i +: 2] != 2'b11);

        // First eligible index at or after rr_ptr, wrapping.
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!win_found && (i == idx) && elig[i]) begin
                    win_found = 1'b1;
                    win_c     = 3'(i);
                end
            end
        end

        for (int i = 0; i < NUM_CORES; i++) begin
            if (3'(i) == win_c) begin
                win_msg  = req_msg[2*i +: 2];
                win_addr = req_addr[ADDR_W*i +: ADDR_W];
            end
        end

        // Listener view excludes the requester; owner is the lowest M index.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (3'(i) != bcast_src) begin
                if (snoop_state[2*i +: 2] != 2'b00) hit_c = 1'b1;
                if (snoop_state[2*i +: 2] == 2'b11 && !own_found_c) begin
                    own_found_c = 1'b1;
                    own_c       = 3'(i);
                end
            end
        end

        for (int i = 0; i < NUM_CORES; i++)
            if (3'(i) == owner_q) own_wb = snoop_wb[i];
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nx        = state;
        cap_msg_nx      = cap_msg;
        hit_nx          = hit_q;
        owner_nx        = owner_q;
        rr_ptr_nx       = rr_ptr;
        wb_cnt_nx       = wb_cnt;
        wb_seen_nx      = wb_seen;
        req_ready_nx    = '0;
        bcast_valid_nx  = 1'b0;
        bcast_msg_nx    = 2'b11;
        bcast_addr_nx   = bcast_addr;
        bcast_src_nx    = bcast_src;
        listen_trans_nx = listen_trans;
        mem_wb_valid_nx = mem_wb_valid;
        mem_wb_src_nx   = mem_wb_src;
        exec_valid_nx   = 1'b0;
        exec_sel_nx     = '0;
        exec_trans_nx   = 3'b111;
        err_nx          = err;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = SNOOP;
                    for (int i = 0; i < NUM_CORES; i++)
                        req_ready_nx[i] = (3'(i) == win_c);
                    cap_msg_nx      = win_msg;
                    bcast_valid_nx  = 1'b1;
                    bcast_msg_nx    = win_msg;
                    bcast_addr_nx   = win_addr;
                    bcast_src_nx    = win_c;
                    listen_trans_nx = {win_msg, 1'b0};
                end
            end
            SNOOP: begin
                hit_nx   = hit_c;
                owner_nx = own_c;
                // Invalidates never wait for a write-back, even with an M owner.
                if (own_found_c && cap_msg != 2'b10) begin
                    state_nx   = WB_WAIT;
                    wb_cnt_nx  = 4'd0;
                    wb_seen_nx = 1'b0;
                end else begin
                    state_nx      = RESP;
                    exec_valid_nx = 1'b1;
                    for (int i = 0; i < NUM_CORES; i++)
                        exec_sel_nx[i] = (3'(i) == bcast_src);
                    exec_trans_nx = resp_code(cap_msg, hit_c);
                end
            end
            WB_WAIT: begin
                wb_cnt_nx = wb_cnt + 4'd1;
                // A write-back flag and an ack in the same cycle complete at once.
                if ((wb_seen || own_wb) && mem_wb_ack) begin
                    mem_wb_valid_nx = 1'b0;
                    state_nx        = RESP;
                end else if (wb_cnt == 4'(WB_TIMEOUT - 1)) begin
                    err_nx          = 1'b1;
                    mem_wb_valid_nx = 1'b0;
                    state_nx        = RESP;
                end else if (own_wb && !wb_seen) begin
                    wb_seen_nx      = 1'b1;
                    mem_wb_valid_nx = 1'b1;
                    mem_wb_src_nx   = owner_q;
                end
                if (state_nx == RESP) begin
                    exec_valid_nx = 1'b1;
                    for (int i = 0; i < NUM_CORES; i++)
                        exec_sel_nx[i] = (3'(i) == bcast_src);
                    exec_trans_nx = resp_code(cap_msg, hit_q);
                end
            end
            RESP: begin
                state_nx  = IDLE;
                rr_ptr_nx = (bcast_src == 3'(NUM_CORES - 1)) ? 3'd0 : bcast_src + 3'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr       <= 3'd0;
            wb_cnt       <= 4'd0;
            wb_seen      <= 1'b0;
            req_ready    <= '0;
            bcast_valid  <= 1'b0;
            bcast_msg    <= 2'b11;
            bcast_addr   <= '0;
            bcast_src    <= 3'd0;
            listen_trans <= 3'b000;
            mem_wb_valid <= 1'b0;
            mem_wb_src   <= 3'd0;
            exec_valid   <= 1'b0;
            exec_sel     <= '0;
            exec_trans   <= 3'b111;
            err          <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_nx;
            wb_cnt       <= wb_cnt_nx;
            wb_seen      <= wb_seen_nx;
            req_ready    <= req_ready_nx;
            bcast_valid  <= bcast_valid_nx;
            bcast_msg    <= bcast_msg_nx;
            bcast_addr   <= bcast_addr_nx;
            bcast_src    <= bcast_src_nx;
            listen_trans <= listen_trans_nx;
            mem_wb_valid <= mem_wb_valid_nx;
            mem_wb_src   <= mem_wb_src_nx;
            exec_valid   <= exec_valid_nx;
            exec_sel     <= exec_sel_nx;
            exec_trans   <= exec_trans_nx;
            err          <= err_nx;
        end
    end

    // Captured transaction data; only meaningful inside a transaction.
    always_ff @(posedge clock) begin
        cap_msg <= cap_msg_nx;
        hit_q   <= hit_nx;
        owner_q <= owner_nx;
    end

endmodule
